// File: rtl/idex_skid_stage.sv
// idex_skid_stage: valid/ready pipeline register with a 2-entry skid buffer and synchronous flush.
// Control is forced to CTRL_RST on bubble/flush; data is only ever overwritten by new beats.
module idex_skid_stage #(
    parameter int DATA_W = 70,
    parameter int CTRL_W = 9,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);
    // Encoding is {out_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, FULL = 2'b11} state_e;
    state_e            state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] data_q, data_d, skid_data_q, skid_data_d;
    logic [1:0]        occ_q;
    logic              accept, fire;
    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = ~state_q[0] & ~rst;
    assign out_valid = state_q[1];
    assign out_ctrl  = ctrl_q;
    assign out_data  = data_q;
    assign occupancy = occ_q;
    assign accept    = in_valid & in_ready;
    assign fire      = out_valid & out_ready;
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        data_d      = data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d = EMPTY;
            ctrl_d  = CTRL_RST;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d = ONE;
                    ctrl_d  = in_ctrl;
                    data_d  = in_data;
                end
                ONE: if (accept && fire) begin
                    ctrl_d = in_ctrl;
                    data_d = in_data;
                end else if (accept) begin
                    state_d     = FULL;
                    skid_ctrl_d = in_ctrl;
                    skid_data_d = in_data;
                end else if (fire) begin
                    state_d = EMPTY;
                    ctrl_d  = CTRL_RST;
                end
                FULL: if (fire) begin
                    state_d = ONE;
                    ctrl_d  = skid_ctrl_q;
                    data_d  = skid_data_q;
                end
                default: begin
                    state_d = EMPTY;
                    ctrl_d  = CTRL_RST;
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            ctrl_q      <= CTRL_RST;
            data_q      <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            occ_q       <= {1'b0, state_d[1]} + {1'b0, state_d[0]};
        end
    end
endmodule

// File: tb/tb_idex_skid_stage.sv
// tb_idex_skid_stage: directed and random stimulus checked every cycle against a FIFO-queue model,
// plus literal expectations at the key points of each scenario.
module tb_idex_skid_stage;
    localparam int DW = 70;
    localparam int CW = 9;
    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } beat_t;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    int            checks = 0;
    int            failures = 0;
    beat_t         mq[$];
    idex_skid_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask
    // Model: the stage is a FIFO of at most two beats; the head is what out_* shows.
    always @(posedge clk) begin
        bit acc, fir;
        acc = in_valid && mq.size() < 2 && !rst;
        fir = mq.size() > 0 && out_ready;
        if (rst || flush) mq.delete();
        else begin
            if (fir) void'(mq.pop_front());
            if (acc) mq.push_back('{ctrl: in_ctrl, data: in_data});
        end
    end
    always @(negedge clk) begin
        chk("out_valid", out_valid, mq.size() > 0);
        chk("in_ready", in_ready, mq.size() < 2 && !rst);
        chk("occupancy", occupancy, mq.size());
        chk("out_ctrl", out_ctrl, mq.size() > 0 ? mq[0].ctrl : '0);
        if (mq.size() > 0) chk("out_data", out_data, mq[0].data);
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic iv, input logic orr, input logic fl, input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = iv; out_ready = orr; flush = fl; in_ctrl = c; in_data = d;
    endtask
    initial begin
        #1;
        chk("rst_in_ready", in_ready, 0);
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_in_ready_released", in_ready, 1);
        // Streaming at one beat per cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, 9'h1FF, DW'(i));
            cyc();
            chk("stream_data", out_data, i);
            chk("stream_ctrl", out_ctrl, 9'h1FF);
            chk("stream_occ", occupancy, 1);
            chk("stream_in_ready", in_ready, 1);
        end
        drive(0, 1, 0, '0, '0);
        cyc();
        chk("stream_drained", out_valid, 0);
        // Backpressure: A, B accepted, C held off until the skid drains.
        drive(1, 0, 0, 9'h0A1, 70'hA);
        cyc();
        drive(1, 0, 0, 9'h0B2, 70'hB);
        cyc();
        chk("bp_occ2", occupancy, 2);
        chk("bp_in_ready0", in_ready, 0);
        drive(1, 0, 0, 9'h0C3, 70'hC);
        cyc();
        chk("bp_stall_data", out_data, 70'hA);
        chk("bp_stall_ctrl", out_ctrl, 9'h0A1);
        drive(1, 1, 0, 9'h0C3, 70'hC);
        cyc();
        chk("bp_out_B", out_data, 70'hB);
        chk("bp_occ1", occupancy, 1);
        cyc();
        chk("bp_out_C", out_data, 70'hC);
        chk("bp_ctrl_C", out_ctrl, 9'h0C3);
        drive(0, 1, 0, '0, '0);
        cyc();
        chk("bp_empty", out_valid, 0);
        // Flush while FULL with C offered.
        drive(1, 0, 0, 9'h011, 70'h1A);
        cyc();
        drive(1, 0, 0, 9'h022, 70'h1B);
        cyc();
        drive(1, 0, 1, 9'h033, 70'h1C);
        cyc();
        chk("fl_valid", out_valid, 0);
        chk("fl_ctrl", out_ctrl, 0);
        chk("fl_occ", occupancy, 0);
        chk("fl_in_ready", in_ready, 1);
        drive(0, 1, 0, '0, '0);
        cyc();
        chk("fl_no_C", out_valid, 0);
        // Flush coinciding with fire, then D appears one cycle after accept.
        drive(1, 0, 0, 9'h044, 70'h2A);
        cyc();
        drive(0, 1, 1, '0, '0);
        cyc();
        chk("flf_empty", occupancy, 0);
        drive(1, 1, 0, 9'h055, 70'h2D);
        cyc();
        chk("flf_D_valid", out_valid, 1);
        chk("flf_D_data", out_data, 70'h2D);
        drive(0, 1, 0, '0, '0);
        cyc();
        // Reset while FULL.
        drive(1, 0, 0, 9'h066, 70'h3A);
        cyc();
        drive(1, 0, 0, 9'h077, 70'h3B);
        cyc();
        drive(1, 0, 0, 9'h088, 70'h3C);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        cyc();
        rst = 1'b0;
        drive(0, 0, 0, '0, '0);
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ctrl", out_ctrl, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_occ", occupancy, 0);
        // Random traffic with occasional flush; the per-cycle compare covers order and bubbles.
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0,
                  CW'($urandom), {6'($urandom), 32'($urandom), 32'($urandom)});
            cyc();
        end
        drive(0, 1, 0, '0, '0);
        cyc(); cyc(); cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/idex_skid_stage.md
Name: idex_skid_stage

Overview:
- Parametrised successor to the fixed ID/EX register: a generic pipeline stage register with a valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
- Carries a control bundle, which is zeroed on bubble/flush, and a data bundle, which is held as is.
- Sits between ID and EX, and is reusable at EX/MEM and MEM/WB.
- Lets hazard logic stall downstream without a combinational ready path back into ID.

Parameters:
- DATA_W, 70, width of data bundle (RD1, RD2, immediate, funct, forwarded reg IDs concatenated).
- CTRL_W, 9, width of control bundle (R15, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOP[1:0]).
- CTRL_RST, 0, value of out_ctrl on reset, flush and bubble; width CTRL_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous flush, e.g. branch taken or IDEX_FLUSH.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  control bundle from control unit.
- in_data  in  DATA_W  data bundle from RF/decode.
- out_valid  out  1  out_* hold a live instruction.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  registered control bundle.
- out_data  out  DATA_W  registered data bundle.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Reset and clocking:
  - One clock, synchronous active-high reset (rst), sampled on rising clk.
  - Reset values: out_valid=0, out_ctrl=CTRL_RST, out_data=0, skid entry invalid, skid regs=0, occupancy=0.
  - in_ready=0 while rst=1.
- Handshake and timing:
  - Accept = in_valid & in_ready. Fire = out_valid & out_ready.
  - in_ready = ~skid_valid & ~rst. It is driven from a register; no combinational path from out_ready to in_ready.
  - Latency: a beat accepted in cycle N appears on out_* in cycle N+1 if the main entry is empty or firing.
- State: {out_valid, skid_valid}, giving EMPTY(0,0), ONE(1,0), FULL(1,1). (0,1) is illegal and must never occur.
- Transitions when flush=0:
  - EMPTY + accept -> ONE; main <= in.
  - ONE + accept + fire -> ONE; main <= in.
  - ONE + accept + ~fire -> FULL; skid <= in.
  - ONE + ~accept + fire -> EMPTY.
  - FULL + fire -> ONE; main <= skid. No accept is possible in FULL.
  - All other cases hold state.
- Ordering: strict FIFO; beats are never duplicated or dropped except by flush.
- Flush:
  - Highest priority after rst.
  - Next state is EMPTY, and out_ctrl <= CTRL_RST.
  - out_data and skid data are held (don't care).
  - A beat accepted in the same cycle as flush is discarded.
  - A beat firing in the same cycle as flush counts as delivered; downstream already sampled it.
- Bubble: whenever out_valid is 0, out_ctrl must equal CTRL_RST, so RegWrite/MemWrite/Branch are never spuriously high.
- Stall: out_ready=0 holds out_* stable, bit for bit, for as long as out_valid=1.
- occupancy = out_valid + skid_valid, registered.
- Reset mid-operation: all in-flight beats are discarded; state is EMPTY on the next edge.
- Throughput: sustains 1 beat/cycle when out_ready=1 continuously.

Test Plan:
- Reset then stream: 8 beats with in_data=i, in_ctrl=9'h1FF, out_ready=1 -> out_data=0..7 on cycles 1..8 after first accept; in_ready stays 1; occupancy stays 1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> accepts 2 beats (A, B), then in_ready=0, occupancy=2. out_ready=1 -> out_data A, then B, then next beat; no loss, no duplication.
- Flush in FULL: A in main, B in skid, C offered, flush=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; C never appears on out_*.
- Flush with simultaneous fire: out_ready=1 and flush=1 while A is valid -> A counted delivered once; next cycle EMPTY; the following accepted beat D appears 1 cycle after accept.
- Reset mid-stream: FULL state, rst=1 for 1 cycle -> in_ready=0 during rst; after release out_valid=0, out_ctrl=CTRL_RST, out_data=0, occupancy=0.
- Bubble control: random in_valid/out_ready for 10k cycles -> scoreboard order matches; out_ctrl==CTRL_RST whenever out_valid=0; never skid_valid=1 with out_valid=0.
